// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, command record and sequencer states for the ALU command path
// ALU_SEQ_CHAIN_EN adds a chain bit to each queued command.
package alu_pkg;

    localparam int DATA_W = 32;

    localparam logic [3:0] OP_HOLD = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_MUL  = 4'd3;
    localparam logic [3:0] OP_DIV  = 4'd4;
    localparam logic [3:0] OP_REM  = 4'd5;
    localparam logic [3:0] OP_AND  = 4'd6;
    localparam logic [3:0] OP_OR   = 4'd7;
    localparam logic [3:0] OP_XOR  = 4'd8;
    localparam logic [3:0] OP_NOT  = 4'd9;
    localparam logic [3:0] OP_NAND = 4'd10;
    localparam logic [3:0] OP_NOR  = 4'd11;
    localparam logic [3:0] OP_XNOR = 4'd12;
    localparam logic [3:0] OP_SHL  = 4'd13;
    localparam logic [3:0] OP_SHR  = 4'd14;
    localparam logic [3:0] OP_ZERO = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CAPTURE,
        ST_RESPOND
    } seq_state_t;

    typedef struct packed {
`ifdef ALU_SEQ_CHAIN_EN
        logic              chain;
`endif
        logic [3:0]        opcode;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } cmd_t;

    // A zero divisor never reaches the ALU; the command is turned into OP_ZERO.
    function automatic logic is_div_by_zero(input logic [3:0] opcode, input logic [DATA_W-1:0] b);
        return ((opcode == OP_DIV) || (opcode == OP_REM)) && (b == '0);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - first-word-fall-through command FIFO with asynchronous reset
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 68
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still takes a push.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - queues ALU commands, issues them one at a time, returns results in order
// ALU_SEQ_CHAIN_EN adds cmd_chain: alu_a takes the previous result instead of cmd_a.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ALU_LAT    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_opcode,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
`ifdef ALU_SEQ_CHAIN_EN
    input  logic              cmd_chain,
`endif
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_opcode,
    input  logic [DATA_W-1:0] alu_c,
    input  logic              alu_err,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_err,
    output logic              rsp_divz
);

    localparam int WCW = (ALU_LAT > 2) ? $clog2(ALU_LAT - 1) : 1;

    cmd_t              push_cmd;
    cmd_t              head_cmd;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;

    seq_state_t        state;
    logic [WCW-1:0]    wait_cnt;
    logic [3:0]        cur_op;
    logic              divz_flag;

    logic              start_issue;
    logic [DATA_W-1:0] issue_a;
    logic [3:0]        issue_op;
    logic              issue_divz;

    always_comb begin
        push_cmd.opcode = cmd_opcode;
        push_cmd.a      = cmd_a;
        push_cmd.b      = cmd_b;
`ifdef ALU_SEQ_CHAIN_EN
        push_cmd.chain  = cmd_chain;
`endif
    end

    assign fifo_push = cmd_valid && cmd_ready;
    assign fifo_pop  = (state == ST_ISSUE);
    assign cmd_ready = !fifo_full || fifo_pop;

    alu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(cmd_t))
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_cmd),
        .pop       (fifo_pop),
        .pop_data  (head_cmd),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // The FIFO head is loaded onto the ALU bus on the edge that enters ISSUE.
    assign start_issue = !fifo_empty &&
                         ((state == ST_IDLE) || ((state == ST_RESPOND) && rsp_ready));

    always_comb begin
        issue_divz = is_div_by_zero(head_cmd.opcode, head_cmd.b);
        issue_op   = issue_divz ? OP_ZERO : head_cmd.opcode;
        issue_a    = head_cmd.a;
`ifdef ALU_SEQ_CHAIN_EN
        if (head_cmd.chain) begin
            issue_a = rsp_result;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            cur_op     <= OP_HOLD;
            divz_flag  <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= OP_HOLD;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            rsp_divz   <= 1'b0;
        end else begin
            if (start_issue) begin
                alu_a      <= issue_a;
                alu_b      <= head_cmd.b;
                alu_opcode <= issue_op;
                cur_op     <= head_cmd.opcode;
                divz_flag  <= issue_divz;
            end
            case (state)
                ST_IDLE: begin
                    if (start_issue) begin
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (ALU_LAT == 1) begin
                        alu_opcode <= OP_HOLD;
                        state      <= ST_CAPTURE;
                    end else begin
                        wait_cnt <= WCW'(ALU_LAT - 2);
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        alu_opcode <= OP_HOLD;
                        state      <= ST_CAPTURE;
                    end else begin
                        wait_cnt <= wait_cnt - WCW'(1);
                    end
                end
                ST_CAPTURE: begin
                    // ERR follows the A+B carry for every opcode; only ADD reports it.
                    rsp_result <= alu_c;
                    rsp_err    <= (cur_op == OP_ADD) && alu_err;
                    rsp_divz   <= divz_flag;
                    rsp_valid  <= 1'b1;
                    state      <= ST_RESPOND;
                end
                ST_RESPOND: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= start_issue ? ST_ISSUE : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed and random checks of alu_cmd_sequencer against an ALU breadboard model
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    localparam int DEPTH = 4;
    localparam int LAT   = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_opcode;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic        cmd_chain;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_opcode;
    logic [31:0] alu_c;
    logic        alu_err;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_err;
    logic        rsp_divz;

    int n_checks = 0;
    int n_errors = 0;
    int n_rsp    = 0;
    bit rnd_ready = 0;

    alu_cmd_sequencer #(
        .FIFO_DEPTH (DEPTH),
        .ALU_LAT    (LAT)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_opcode (cmd_opcode),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
`ifdef ALU_SEQ_CHAIN_EN
        .cmd_chain  (cmd_chain),
`endif
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_c      (alu_c),
        .alu_err    (alu_err),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .rsp_divz   (rsp_divz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_MUL:  return a * b;
            OP_DIV:  return (b == 0) ? 32'd0 : a / b;
            OP_REM:  return (b == 0) ? 32'd0 : a % b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOT:  return ~a;
            OP_NAND: return ~(a & b);
            OP_NOR:  return ~(a | b);
            OP_XNOR: return ~(a ^ b);
            OP_SHL:  return a << b[4:0];
            OP_SHR:  return a >> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic carry_of(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32];
    endfunction

    // ALU breadboard: an opcode on the bus lands in alu_c/alu_err LAT edges later; HOLD keeps the accumulator.
    logic [3:0]  p_op [LAT-1];
    logic [31:0] p_a  [LAT-1];
    logic [31:0] p_b  [LAT-1];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_c   <= 32'd0;
            alu_err <= 1'b0;
            for (int i = 0; i < LAT - 1; i++) begin
                p_op[i] <= OP_HOLD;
                p_a[i]  <= 32'd0;
                p_b[i]  <= 32'd0;
            end
        end else begin
            p_op[0] <= alu_opcode;
            p_a[0]  <= alu_a;
            p_b[0]  <= alu_b;
            for (int i = 1; i < LAT - 1; i++) begin
                p_op[i] <= p_op[i-1];
                p_a[i]  <= p_a[i-1];
                p_b[i]  <= p_b[i-1];
            end
            if (p_op[LAT-2] != OP_HOLD) begin
                alu_c   <= alu_fn(p_op[LAT-2], p_a[LAT-2], p_b[LAT-2]);
                alu_err <= carry_of(p_a[LAT-2], p_b[LAT-2]);
            end
        end
    end

    // Reference: expected response per accepted command, in acceptance order.
    logic [33:0] exp_q [$];
    logic [31:0] ref_acc  = 32'd0;
    logic [31:0] ref_last = 32'd0;

    task automatic model_accept(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic ch);
        logic [31:0] ea;
        logic [31:0] res;
        logic        dz;
        logic        er;
        ea = ch ? ref_last : a;
        dz = ((op == OP_DIV) || (op == OP_REM)) && (b == 0);
        if (dz) begin
            res     = 32'd0;
            ref_acc = 32'd0;
        end else if (op == OP_HOLD) begin
            res = ref_acc;
        end else begin
            res     = alu_fn(op, ea, b);
            ref_acc = res;
        end
        er       = (op == OP_ADD) && carry_of(ea, b);
        ref_last = res;
        exp_q.push_back({dz, er, res});
    endtask

    logic        prev_stall = 1'b0;
    logic [34:0] prev_rsp;
    logic [31:0] last_rsp_result = 32'd0;

    always @(negedge clk) begin
        if (reset) begin
            prev_stall <= 1'b0;
        end else begin
            if ((alu_opcode == OP_DIV) || (alu_opcode == OP_REM)) begin
                check("div_guard_b_nonzero", alu_b != 0, 1);
            end
            if (prev_stall) begin
                check("rsp_stable_while_stalled", {rsp_valid, rsp_divz, rsp_err, rsp_result}, prev_rsp);
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    check("rsp_result", rsp_result, exp_q[0][31:0]);
                    check("rsp_err", rsp_err, exp_q[0][32]);
                    check("rsp_divz", rsp_divz, exp_q[0][33]);
                    exp_q.delete(0);
                end
                n_rsp           <= n_rsp + 1;
                last_rsp_result <= rsp_result;
            end
            prev_stall <= rsp_valid && !rsp_ready;
            prev_rsp   <= {rsp_valid, rsp_divz, rsp_err, rsp_result};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) rsp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic ch);
        logic rdy;
        bit   done;
        done       = 0;
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_a      = a;
        cmd_b      = b;
        cmd_chain  = ch;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            rdy = cmd_ready;
            @(posedge clk);
            if (rdy) begin
                model_accept(op, a, b, ch);
                done = 1;
            end
            #1;
            if (rnd_ready) rsp_ready = 1'($urandom_range(0, 1));
        end
        cmd_valid = 1'b0;
        if (!done) check("send_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 600; i++) begin
            if (exp_q.size() == 0 && !rsp_valid) break;
            tick();
        end
        check("drain_all_responses", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          n_acc;
        int          rsp0;
        logic        rdy;
        logic        seen;
        logic [31:0] bp_a [8];
        logic [31:0] bp_b [8];

        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_opcode = OP_HOLD;
        cmd_a      = 32'd0;
        cmd_b      = 32'd0;
        cmd_chain  = 1'b0;
        rsp_ready  = 1'b1;
        #2;
        check("reset_alu_opcode", alu_opcode, OP_HOLD);
        check("reset_alu_a", alu_a, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_result", {rsp_err, rsp_divz, rsp_result}, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("post_reset_cmd_ready", cmd_ready, 1);

        // ADD 5+7 with issue-to-valid latency measured on the ALU bus.
        send(OP_ADD, 32'd5, 32'd7, 1'b0);
        for (int i = 0; i < 20 && alu_opcode != OP_ADD; i++) tick();
        check("add_issued", alu_opcode, OP_ADD);
        lat = 0;
        for (int i = 0; i < 20 && !rsp_valid; i++) begin
            tick();
            lat++;
        end
        check("issue_to_valid_latency", lat, LAT + 1);
        check("add_5_7_result", rsp_result, 32'd12);
        check("add_5_7_err", rsp_err, 0);
        drain();

        send(OP_ADD, 32'hFFFF_FFFF, 32'd1, 1'b0);
        send(OP_SUB, 32'hFFFF_FFFF, 32'd1, 1'b0);
        drain();
        check("sub_after_carry_result", last_rsp_result, 32'hFFFF_FFFE);

        send(OP_DIV, 32'd7, 32'd0, 1'b0);
        send(OP_REM, 32'd17, 32'd5, 1'b0);
        send(OP_HOLD, 32'd99, 32'd0, 1'b0);
        drain();
        check("hold_returns_accumulator", last_rsp_result, 32'd2);

        // Backpressure: stalled response plus a full FIFO bounds acceptance at DEPTH+1.
        for (int k = 0; k < 8; k++) begin
            bp_a[k] = 32'(k * 100);
            bp_b[k] = 32'(k + 1);
        end
        rsp_ready = 1'b0;
        n_acc     = 0;
        rsp0      = n_rsp;
        for (int cyc = 0; cyc < 16; cyc++) begin
            cmd_valid  = (n_acc < 8);
            cmd_opcode = OP_ADD;
            cmd_a      = bp_a[n_acc % 8];
            cmd_b      = bp_b[n_acc % 8];
            @(negedge clk);
            rdy = cmd_ready;
            @(posedge clk);
            if (cmd_valid && rdy) begin
                model_accept(OP_ADD, bp_a[n_acc], bp_b[n_acc], 1'b0);
                n_acc++;
            end
            #1;
        end
        cmd_valid = 1'b0;
        check("bp_accepted", n_acc, DEPTH + 1);
        check("bp_cmd_ready_low", cmd_ready, 0);
        rnd_ready = 1;
        for (int k = DEPTH + 1; k < 8; k++) send(OP_ADD, bp_a[k], bp_b[k], 1'b0);
        drain();
        check("bp_responses_delivered", n_rsp - rsp0, 8);

        // Random commands against the reference with random response stalls.
        for (int k = 0; k < 40; k++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            logic        ch;
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
            ch = 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
            ch = 1'($urandom_range(0, 1));
`endif
            send(op, a, b, ch);
            if ($urandom_range(0, 3) == 0) tick();
        end
        drain();
        rnd_ready = 0;
        rsp_ready = 1'b1;

        // Reset during WAIT drops the in-flight command.
        send(OP_ADD, 32'd9, 32'd10, 1'b0);
        for (int i = 0; i < 20 && alu_opcode != OP_ADD; i++) tick();
        tick();
        #3;
        reset = 1'b1;
        #1;
        check("midreset_alu_opcode", alu_opcode, OP_HOLD);
        check("midreset_alu_ab", {alu_a, alu_b}, 0);
        check("midreset_rsp", {rsp_valid, rsp_err, rsp_divz, rsp_result}, 0);
        exp_q.delete();
        ref_acc  = 32'd0;
        ref_last = 32'd0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("post_midreset_cmd_ready", cmd_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen = seen | rsp_valid;
        end
        check("dropped_cmd_no_rsp", seen, 0);
        send(OP_ADD, 32'd20, 32'd22, 1'b0);
        drain();
        check("post_reset_add_result", last_rsp_result, 32'd42);

`ifdef ALU_SEQ_CHAIN_EN
        send(OP_ADD, 32'd3, 32'd4, 1'b0);
        send(OP_MUL, 32'hDEAD_BEEF, 32'd6, 1'b1);
        drain();
        check("chain_mul_result", last_rsp_result, 32'd42);
`endif

        check("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
